uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer between the bus-side UART register interface and async_transmitter.
- Accepts bytes from a one-cycle write strobe and stores them in a power-of-2 FIFO.
- Drains bytes one at a time into the transmitter using its TxD_start/TxD_data/TxD_busy handshake.
- Lets software queue bursts without polling TxD_busy per byte.

Parameters:
- DEPTH, 16: FIFO entries; power of 2, >= 2.
- AW, log2(DEPTH): pointer index width; derived, do not override.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; asynchronous, active-high.
- wr_en  input  1  write strobe; one byte per cycle.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- level  output  AW+1  current occupancy, 0..DEPTH.
- tx_start  output  1  to TxD_start; one-cycle pulse.
- tx_data  output  8  to TxD_data; valid while tx_start=1.
- tx_busy  input  1  from TxD_busy.
- ovf  output  1  sticky overflow flag; present only with UART_TX_FIFO_OVF_EN.
- ovf_clr  input  1  clears ovf; present only with UART_TX_FIFO_OVF_EN.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, state=IDLE.
  - Outputs after reset: full=0, empty=1, level=0, tx_start=0, tx_data=8'h00, ovf=0.
- Pointers are AW+1 bits.
  - level = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - full = (level==DEPTH); empty = (level==0). Both are combinational from the registered pointers.
  - Pointers wrap naturally; no special case is needed at index DEPTH-1 -> 0.
- Write:
  - On a clk edge with wr_en=1 and full=0: mem[wr_ptr[AW-1:0]] <= wr_data; wr_ptr++.
  - wr_en=1 with full=1: byte dropped, pointers unchanged. This applies even if a pop happens on the same edge; full is the registered pre-edge value.
- FSM states:
  - IDLE: if !empty && !tx_busy, go to START and register tx_data <= mem[rd_ptr].
  - START: tx_start=1 for exactly this one cycle; rd_ptr++ on the exit edge; go to HOLD unconditionally.
  - HOLD: tx_start=0; stay while tx_busy=1; go to IDLE when tx_busy=0.
- tx_start is a registered decode of state==START; it never stays high for two consecutive cycles.
- tx_data holds its value outside START; the transmitter latches it, so it does not need to hold.
- HOLD always lasts at least one cycle, which guards against TxD_busy being combinational with TxD_start.
- Latency:
  - Write at edge N into an empty FIFO with FSM in IDLE and tx_busy=0: tx_start is high from edge N+1 to edge N+2.
  - Back-to-back bytes: next tx_start occurs 2 edges after tx_busy falls.
- Simultaneous write and pop on the same edge: both take effect; level is unchanged.
- Write in the same cycle the FIFO goes empty: the FSM sees the byte on the following IDLE evaluation. No byte is lost or duplicated.
- tx_busy=1 while in IDLE (external transmitter activity): the FSM waits in IDLE.
- Reset mid-operation:
  - FIFO contents are discarded and the FSM returns to IDLE.
  - A transmitter frame already in progress is unaffected; the FSM waits for tx_busy=0 before the next start.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- Defined:
  - ovf sets on any edge where wr_en=1 and full=1.
  - ovf clears on an edge with ovf_clr=1 and no overflow. Set wins when both occur on the same edge.
  - ovf resets to 0.
- Undefined: ovf and ovf_clr ports and logic are absent; overflowing writes are silently dropped.

Decomposition:
- Package uart_pkg:
  - FSM state encoding: IDLE=2'd0, START=2'd1, HOLD=2'd2.
  - UART_DATA_W=8.
  - Default FIFO depth constant.
- Sub-module uart_fifo_mem:
  - DEPTH x 8 storage array with one write port and one asynchronous read port.
  - No reset on the array, so it can map to distributed RAM.
- Pointer, level and FSM logic stay in uart_tx_fifo.

Test Plan:
- Single byte: write 8'hA5 at edge 0 with tx_busy=0.
  - tx_start high during cycle 1-2 with tx_data=8'hA5.
  - level returns to 0 after edge 2; empty=1.
- Burst with transmitter model: write 8'h01..8'h10 on consecutive cycles, DEPTH=16, busy for 100 cycles after each start.
  - full=1 after the 16th write.
  - Exactly 16 tx_start pulses, data in order 01..10, each ≥2 edges after busy falls.
- Overflow: fill 16 bytes, then write 8'hFF with tx_busy held 1.
  - Byte dropped, level stays 16.
  - With macro: ovf=1; ovf_clr then gives ovf=0.
- Simultaneous: level=16, FSM pops on the same edge as wr_en with 8'h77.
  - Write dropped, level=15, 8'h77 never transmitted.
- Simultaneous at level=5: pop plus write on the same edge.
  - level stays 5; the new byte is transmitted last.
- Reset mid-burst: assert rst while level=7 and FSM in HOLD.
  - Immediately: level=0, empty=1, tx_start=0.
  - After release, no tx_start until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared constants and FSM encoding for the UART transmit buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// uart_fifo_mem : DEPTH x 8 storage, one write port, asynchronous read port
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_DATA_W-1:0] o_rdata
);

  // Left unreset so the array can map onto distributed RAM.
  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : byte FIFO feeding async_transmitter via TxD_start/busy.
// Optional sticky overflow flag when UART_TX_FIFO_OVF_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_busy
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                   ovf,
  input  logic                   ovf_clr
`endif
);

  localparam logic [AW:0] c_PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] c_FULL_LVL = (AW+1)'(DEPTH);

  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [AW:0]            w_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_rdata;
  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == c_FULL_LVL);
  assign w_empty = (w_level == '0);
  assign w_push  = wr_en && !w_full;
  assign w_pop   = (r_state == START);

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_wr_en (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == START);
      if (w_state_nxt == START) r_tx_data <= w_rdata;
    end
  end

  // HOLD always spends one cycle before looking at busy again.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty && !tx_busy) w_state_nxt = START;
      START:   w_state_nxt = HOLD;
      HOLD:    if (!tx_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (wr_en && w_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = w_level;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : directed + randomized bench for uart_tx_fifo with a
// queue-based reference model and a transmitter busy model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_busy = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_start;
  logic [7:0]    tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic          ovf;
  logic          ovf_clr = 1'b0;
`endif

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: bytes waiting, whether a frame hand-off is in flight,
  // and what the transmitter interface should show this cycle.
  logic [7:0] q[$];
  logic [7:0] rec[$];
  bit         m_start  = 1'b0;
  bit         m_flight = 1'b0;
  logic [7:0] m_data   = 8'h00;
  bit         m_ovf    = 1'b0;
  int         bcnt     = 0;
  int         n_vec    = 0;
  int         n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A start needs a byte, an idle transmitter and no hand-off in flight;
  // the byte leaves the FIFO on the edge closing the start cycle, and the
  // hand-off ends on a later edge that sees busy low.
  task automatic model_edge(input logic wr, input logic [7:0] d, input logic busy, input logic clr);
    bit pre_full;
    bit begin_tx;
    bit release_tx;
    pre_full   = (q.size() == DEPTH);
    begin_tx   = !m_flight && (q.size() != 0) && !busy;
    release_tx = m_flight && !m_start && !busy;
    if (begin_tx) m_data = q[0];
    if (m_start) void'(q.pop_front());
    if (wr && !pre_full) q.push_back(d);
    if (wr && pre_full) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    if (begin_tx)        m_flight = 1'b1;
    else if (release_tx) m_flight = 1'b0;
    m_start = begin_tx;
  endtask

  task automatic model_clear();
    q.delete();
    m_start  = 1'b0;
    m_flight = 1'b0;
    m_data   = 8'h00;
    m_ovf    = 1'b0;
  endtask

  task automatic check_outputs();
    chk("level",    32'(level),    32'(q.size()));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data",  32'(tx_data),  32'(m_data));
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf",      32'(ovf),      32'(m_ovf));
`endif
    if (tx_start === 1'b1) rec.push_back(tx_data);
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic busy, input logic clr);
    wr_en   = wr;
    wr_data = d;
    tx_busy = busy;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = clr;
`endif
    @(posedge clk);
    model_edge(wr, d, busy, clr);
    @(negedge clk);
    check_outputs();
  endtask

  // Transmitter model: busy for len cycles after each start, plus ext busy.
  task automatic xstep(input logic wr, input logic [7:0] d, input int len,
                       input logic ext, input logic clr);
    logic busy;
    if (m_start) bcnt = len;
    busy = (bcnt > 0) || ext;
    if (bcnt > 0) bcnt--;
    step(wr, d, busy, clr);
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    rst     = 1'b1;
    #1;
    model_clear();
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_ovf",      32'(ovf),      32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int len);
    int guard;
    guard = 0;
    while ((q.size() != 0 || m_flight) && guard < 4000) begin
      xstep(1'b0, 8'h00, len, 1'b0, 1'b0);
      guard++;
    end
    chk("drain_timeout", 32'(guard >= 4000), 32'd0);
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (!m_start && guard < 50) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    chk("start_timeout", 32'(guard >= 50), 32'd0);
  endtask

  initial begin
    int n77;
    repeat (2) @(negedge clk);
    do_reset();

    // Single byte
    rec.delete();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_level1", 32'(level), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_start", 32'(tx_start), 32'd1);
    chk("a5_data",  32'(tx_data),  32'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_empty", 32'(empty), 32'd1);
    chk("a5_start_low", 32'(tx_start), 32'd0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Burst of 16 against a slow transmitter
    do_reset();
    rec.delete();
    bcnt = 0;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    chk("burst_full", 32'(full), 32'd1);
    drain(100);
    chk("burst_count", 32'(rec.size()), 32'd16);
    for (int i = 0; i < 16 && i < rec.size(); i++) chk("burst_order", 32'(rec[i]), 32'(i + 1));

    // Overflow then pop/write collision at full
    do_reset();
    rec.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", 32'(ovf), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'd0);
`endif
    wait_start();
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("coll_full_level", 32'(level), 32'd15);
    bcnt = 0;
    drain(3);
    n77 = 0;
    foreach (rec[i]) if (rec[i] == 8'h77) n77++;
    chk("coll_no77", 32'(n77), 32'd0);
    chk("coll_count", 32'(rec.size()), 32'd16);

    // Pop/write collision at level 5
    do_reset();
    rec.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    wait_start();
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("coll5_level", 32'(level), 32'd5);
    bcnt = 0;
    drain(2);
    chk("coll5_count", 32'(rec.size()), 32'd6);
    if (rec.size() != 0) chk("coll5_last", 32'(rec[rec.size() - 1]), 32'hC3);

    // Reset mid-burst while the FSM is holding
    do_reset();
    rec.delete();
    bcnt = 0;
    for (int i = 0; i < 8; i++) xstep(1'b1, 8'(8'h60 + i), 50, 1'b0, 1'b0);
    chk("mid_level7", 32'(level), 32'd7);
    #2;
    do_reset();
    repeat (60) xstep(1'b0, 8'h00, 50, 1'b0, 1'b0);
    chk("mid_no_start", 32'(rec.size()), 32'd1);

    // Randomized traffic
    do_reset();
    bcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      xstep(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 8)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule

`default_nettype wire
